// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the front-end pipeline control logic:
// FSM state encoding, the four-bit control word and the load-use check.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } ctrl_state_t;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam int          FLUSH_CNT_W = 2;

  typedef struct packed {
    logic pc_write_en;
    logic if_id_write_en;
    logic if_id_flush;
    logic id_ex_bubble;
  } ctrl_word_t;

  localparam ctrl_word_t CW_RUN = '{pc_write_en: 1'b1, if_id_write_en: 1'b1,
                                    if_id_flush: 1'b0, id_ex_bubble:   1'b0};
  localparam ctrl_word_t CW_FREEZE = '{pc_write_en: 1'b0, if_id_write_en: 1'b0,
                                       if_id_flush: 1'b0, id_ex_bubble:   1'b0};
  localparam ctrl_word_t CW_SQUASH = '{pc_write_en: 1'b1, if_id_write_en: 1'b1,
                                       if_id_flush: 1'b1, id_ex_bubble:   1'b1};
  localparam ctrl_word_t CW_STALL = '{pc_write_en: 1'b0, if_id_write_en: 1'b0,
                                      if_id_flush: 1'b0, id_ex_bubble:   1'b1};
  localparam ctrl_word_t CW_RESET = '{pc_write_en: 1'b0, if_id_write_en: 1'b0,
                                      if_id_flush: 1'b1, id_ex_bubble:   1'b1};

  // x0 is hard-wired zero, so a load targeting it never creates a dependency.
  function automatic logic load_use(input logic       mem_read,
                                    input logic [4:0] ex_rd,
                                    input logic [4:0] id_rs1,
                                    input logic [4:0] id_rs2);
    return mem_read && (ex_rd != 5'd0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  endfunction

endpackage

// File: rtl/if_id_hazard_ctrl_if.sv
// Bundle of hazard inputs, pipeline control outputs and statistics counters
// exchanged between the CPU datapath (master) and the hazard controller (slave).
interface if_id_hazard_ctrl_if #(
  parameter int CNT_W = 16
);

  logic             IMEM_BUSYWAIT;
  logic             DMEM_BUSYWAIT;
  logic [4:0]       ID_RS1;
  logic [4:0]       ID_RS2;
  logic [4:0]       EX_RD;
  logic             EX_MEM_READ;
  logic             BRANCH_TAKEN;
  logic             PC_WRITE_EN;
  logic             IF_ID_WRITE_EN;
  logic             IF_ID_FLUSH;
  logic             ID_EX_BUBBLE;
  logic [CNT_W-1:0] STALL_COUNT;
  logic [CNT_W-1:0] FLUSH_COUNT;

  modport master (
    output IMEM_BUSYWAIT, DMEM_BUSYWAIT, ID_RS1, ID_RS2, EX_RD, EX_MEM_READ, BRANCH_TAKEN,
    input  PC_WRITE_EN, IF_ID_WRITE_EN, IF_ID_FLUSH, ID_EX_BUBBLE, STALL_COUNT, FLUSH_COUNT
  );

  modport slave (
    input  IMEM_BUSYWAIT, DMEM_BUSYWAIT, ID_RS1, ID_RS2, EX_RD, EX_MEM_READ, BRANCH_TAKEN,
    output PC_WRITE_EN, IF_ID_WRITE_EN, IF_ID_FLUSH, ID_EX_BUBBLE, STALL_COUNT, FLUSH_COUNT
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; used for the stall and flush statistics.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // its inputs from before the edge, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_en && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/if_id_hazard_ctrl.sv
// Front-end hazard sequencer: folds DMEM/IMEM busy-waits, load-use hazards and
// taken branches into one per-cycle control word for PC, IF/ID and ID/EX.
module if_id_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input logic                CLK,
  input logic                RESET,
  if_id_hazard_ctrl_if.slave bus
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  ctrl_state_t            r_state;
  ctrl_state_t            w_state_nxt;
  logic [FLUSH_CNT_W-1:0] r_flush_cnt;
  logic [FLUSH_CNT_W-1:0] w_flush_cnt_nxt;
  logic                   r_pend_br;
  logic                   w_pend_br_nxt;
  logic                   w_flush_entry;
  logic                   w_lu;
  ctrl_word_t             w_ctrl;
  ctrl_word_t             w_out;

  assign w_lu = load_use(bus.EX_MEM_READ, bus.EX_RD, bus.ID_RS1, bus.ID_RS2);

  // NOTE: every signal written here gets a default first, so no path through
  // the priority chain leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_ctrl          = CW_RUN;
    w_state_nxt     = RUN;
    w_flush_cnt_nxt = r_flush_cnt;
    w_pend_br_nxt   = r_pend_br;
    w_flush_entry   = 1'b0;

    if (bus.DMEM_BUSYWAIT) begin
      // Whole front end freezes; a redirect seen now is replayed once memory frees up.
      w_ctrl          = CW_FREEZE;
      w_state_nxt     = MEM_WAIT;
      w_flush_cnt_nxt = '0;
      w_pend_br_nxt   = r_pend_br | bus.BRANCH_TAKEN;
    end else if (r_state == FLUSH) begin
      w_ctrl          = CW_SQUASH;
      w_flush_cnt_nxt = r_flush_cnt - 1'b1;
      w_state_nxt     = (r_flush_cnt <= FLUSH_CNT_W'(1)) ? RUN : FLUSH;
    end else if (bus.BRANCH_TAKEN || r_pend_br) begin
      w_ctrl        = CW_SQUASH;
      w_flush_entry = 1'b1;
      w_pend_br_nxt = 1'b0;
      if (FLUSH_CYCLES > 1) begin
        w_state_nxt     = FLUSH;
        w_flush_cnt_nxt = FLUSH_LOAD;
      end else begin
        w_flush_cnt_nxt = '0;
      end
    end else if (w_lu || bus.IMEM_BUSYWAIT) begin
      w_ctrl = CW_STALL;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state     <= RUN;
      r_flush_cnt <= '0;
      r_pend_br   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
      r_pend_br   <= w_pend_br_nxt;
    end
  end

  // Hold the pipeline squashed and the PC still for as long as reset is low.
  assign w_out = RESET ? w_ctrl : CW_RESET;

  assign bus.PC_WRITE_EN    = w_out.pc_write_en;
  assign bus.IF_ID_WRITE_EN = w_out.if_id_write_en;
  assign bus.IF_ID_FLUSH    = w_out.if_id_flush;
  assign bus.ID_EX_BUBBLE   = w_out.id_ex_bubble;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk     (CLK),
    .rst_n   (RESET),
    .i_en    (~w_ctrl.pc_write_en),
    .o_count (bus.STALL_COUNT)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk     (CLK),
    .rst_n   (RESET),
    .i_en    (w_flush_entry),
    .o_count (bus.FLUSH_COUNT)
  );

endmodule

// File: tb/tb_if_id_hazard_ctrl.sv
// Self-checking bench: two controller instances (FLUSH_CYCLES=2/CNT_W=16 and
// FLUSH_CYCLES=1/CNT_W=4) share stimulus and are compared to a squash-budget model.
module tb_if_id_hazard_ctrl;

  localparam int FC_A = 2;
  localparam int CW_A = 16;
  localparam int FC_B = 1;
  localparam int CW_B = 4;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  if_id_hazard_ctrl_if #(.CNT_W(CW_A)) if_a ();
  if_id_hazard_ctrl_if #(.CNT_W(CW_B)) if_b ();

  if_id_hazard_ctrl #(.FLUSH_CYCLES(FC_A), .CNT_W(CW_A)) u_dut_a (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (if_a)
  );

  if_id_hazard_ctrl #(.FLUSH_CYCLES(FC_B), .CNT_W(CW_B)) u_dut_b (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (if_b)
  );

  // Stimulus currently applied to both instances.
  logic       s_imem, s_dmem, s_mr, s_br;
  logic [4:0] s_rs1, s_rs2, s_rd;

  // Reference model: squash cycles still owed, a parked branch, and event tallies.
  int m_squash [2];
  bit m_pend   [2];
  int m_stall  [2];
  int m_flush  [2];
  int m_fc     [2];
  int m_max    [2];

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Control word packed as {pc_we, if_id_we, if_id_flush, id_ex_bubble}.
  function automatic logic [3:0] exp_word(input int k);
    bit hazard;
    hazard = s_mr && (s_rd != 5'd0) && (s_rd == s_rs1 || s_rd == s_rs2);
    if (s_dmem)                              return 4'b0000;
    if (m_squash[k] > 0 || s_br || m_pend[k]) return 4'b1111;
    if (hazard || s_imem)                    return 4'b0001;
    return 4'b1100;
  endfunction

  function automatic logic [3:0] act_word(input int k);
    if (k == 0) return {if_a.PC_WRITE_EN, if_a.IF_ID_WRITE_EN, if_a.IF_ID_FLUSH, if_a.ID_EX_BUBBLE};
    return {if_b.PC_WRITE_EN, if_b.IF_ID_WRITE_EN, if_b.IF_ID_FLUSH, if_b.ID_EX_BUBBLE};
  endfunction

  function automatic logic [31:0] act_stall(input int k);
    if (k == 0) return 32'(if_a.STALL_COUNT);
    return 32'(if_b.STALL_COUNT);
  endfunction

  function automatic logic [31:0] act_flush(input int k);
    if (k == 0) return 32'(if_a.FLUSH_COUNT);
    return 32'(if_b.FLUSH_COUNT);
  endfunction

  task automatic model_step(input int k, input logic [3:0] word);
    if (!word[3]) m_stall[k] = (m_stall[k] < m_max[k]) ? m_stall[k] + 1 : m_max[k];
    if (s_dmem) begin
      m_pend[k]   = m_pend[k] | s_br;
      m_squash[k] = 0;
    end else if (m_squash[k] > 0) begin
      m_squash[k]--;
    end else if (s_br || m_pend[k]) begin
      m_squash[k] = m_fc[k] - 1;
      m_pend[k]   = 1'b0;
      m_flush[k]  = (m_flush[k] < m_max[k]) ? m_flush[k] + 1 : m_max[k];
    end
  endtask

  task automatic drive();
    if_a.IMEM_BUSYWAIT = s_imem; if_b.IMEM_BUSYWAIT = s_imem;
    if_a.DMEM_BUSYWAIT = s_dmem; if_b.DMEM_BUSYWAIT = s_dmem;
    if_a.EX_MEM_READ   = s_mr;   if_b.EX_MEM_READ   = s_mr;
    if_a.BRANCH_TAKEN  = s_br;   if_b.BRANCH_TAKEN  = s_br;
    if_a.ID_RS1        = s_rs1;  if_b.ID_RS1        = s_rs1;
    if_a.ID_RS2        = s_rs2;  if_b.ID_RS2        = s_rs2;
    if_a.EX_RD         = s_rd;   if_b.EX_RD         = s_rd;
  endtask

  task automatic cycle(input logic imem, input logic dmem, input logic mr, input logic br,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    logic [3:0] w [2];
    @(negedge clk);
    s_imem = imem; s_dmem = dmem; s_mr = mr; s_br = br;
    s_rs1 = rs1; s_rs2 = rs2; s_rd = rd;
    drive();
    #1;
    for (int k = 0; k < 2; k++) begin
      w[k] = exp_word(k);
      check($sformatf("ctrl_word dut%0d", k), 32'(act_word(k)), 32'(w[k]));
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      model_step(k, w[k]);
      check($sformatf("stall_count dut%0d", k), act_stall(k), 32'(m_stall[k]));
      check($sformatf("flush_count dut%0d", k), act_flush(k), 32'(m_flush[k]));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  // Asserts reset away from the clock edge, checks the forced outputs, then releases.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    s_imem = 1'b0; s_dmem = 1'b0; s_mr = 1'b0; s_br = 1'b0;
    s_rs1 = '0; s_rs2 = '0; s_rd = '0;
    drive();
    #1;
    for (int k = 0; k < 2; k++) begin
      m_squash[k] = 0; m_pend[k] = 1'b0; m_stall[k] = 0; m_flush[k] = 0;
      check($sformatf("reset_word dut%0d", k), 32'(act_word(k)), 32'(4'b0011));
      check($sformatf("reset_stall dut%0d", k), act_stall(k), 32'd0);
      check($sformatf("reset_flush dut%0d", k), act_flush(k), 32'd0);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    m_fc[0]  = FC_A; m_max[0] = (1 << CW_A) - 1;
    m_fc[1]  = FC_B; m_max[1] = (1 << CW_B) - 1;

    do_reset();
    idle(1);

    // Load-use on rs2 stalls exactly once; the same load into x0 does not.
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd5, 5'd5);
    check("lu_stall_count", act_stall(0), 32'd1);
    idle(1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    check("lu_x0_no_stall", act_stall(0), 32'd1);

    // Branch and load-use together: flush wins, two squash cycles on dut0.
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 5'd5, 5'd5);
    idle(1);
    check("flush_second_cycle", 32'(if_a.IF_ID_FLUSH), 32'd0);
    check("br_lu_flush_count", act_flush(0), 32'd1);
    check("br_lu_stall_unchanged", act_stall(0), 32'd1);
    idle(1);

    // DMEM busy for 4 cycles with a branch in cycle 2, replayed in cycle 5.
    do_reset();
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    check("dmem_stall_count", act_stall(0), 32'd4);
    check("dmem_flush_count", act_flush(0), 32'd1);
    idle(2);

    // IMEM busy for 3 cycles, then normal flow.
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    idle(1);

    // Reset lands while dut0 is in its squash window.
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0);
    do_reset();
    idle(1);
    check("post_reset_pc_we", 32'(if_a.PC_WRITE_EN), 32'd1);

    // 20 stall cycles saturate the 4-bit counter on dut1.
    do_reset();
    repeat (20) cycle(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    check("sat_stall_4bit", act_stall(1), 32'd15);
    check("sat_stall_16bit", act_stall(0), 32'd20);
    idle(1);

    // Random traffic with register numbers drawn from a small pool to force matches.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(199) == 0) begin
        do_reset();
      end else begin
        cycle(($urandom_range(99) < 20), ($urandom_range(99) < 20),
              ($urandom_range(99) < 50), ($urandom_range(99) < 15),
              5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)));
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/if_id_hazard_ctrl.md
# if_id_hazard_ctrl

Front-end hazard and stall sequencer that drives the write-enable, flush and bubble controls of the PC, the IF/ID register and the ID/EX register. It sits beside the IF/ID pipeline register. Inputs:
- instruction- and data-memory busy-wait signals;
- the load-use hazard check between ID and EX;
- the branch-taken decision from EX.

It resolves these into one consistent per-cycle control word and keeps saturating stall and flush statistics for the CPU testbench.

## Interface
- `FLUSH_CYCLES`, default 1: cycles the FLUSH state is held after a taken branch (1..3).
- `CNT_W`, default 16: width of the statistics counters.
- `CLK` in, 1: system clock; all state updates on the rising edge.
- `RESET` in, 1: asynchronous, active-low reset. Already decided.
- `IMEM_BUSYWAIT` in, 1: instruction cache miss in progress.
- `DMEM_BUSYWAIT` in, 1: data cache access in progress.
- `ID_RS1`, `ID_RS2` in, 5 each: source registers of the instruction in ID.
- `EX_RD` in, 5: destination register of the instruction in EX.
- `EX_MEM_READ` in, 1: the EX instruction is a load.
- `BRANCH_TAKEN` in, 1: the EX-stage branch/jump redirects the PC this cycle.
- `PC_WRITE_EN` out, 1: PC may update.
- `IF_ID_WRITE_EN` out, 1: IF/ID may capture.
- `IF_ID_FLUSH` out, 1: IF/ID loads a NOP (32'h00000013).
- `ID_EX_BUBBLE` out, 1: ID/EX loads control-zero.
- `STALL_COUNT` out, `CNT_W`: cycles with `PC_WRITE_EN`=0.
- `FLUSH_COUNT` out, `CNT_W`: number of FLUSH entries.

## Operation
- States: RUN, MEM_WAIT, FLUSH.
- The load-use hazard (`lu`) is `EX_MEM_READ` & `EX_RD`≠0 & (`EX_RD`==`ID_RS1` | `EX_RD`==`ID_RS2`).
- Outputs are combinational from the current state and inputs. Priority, highest first:
  1. `DMEM_BUSYWAIT`=1, any state: freeze. `PC_WRITE_EN`=0, `IF_ID_WRITE_EN`=0, `IF_ID_FLUSH`=0, `ID_EX_BUBBLE`=0. Next state MEM_WAIT.
  2. FLUSH state: `PC_WRITE_EN`=1, `IF_ID_FLUSH`=1, `ID_EX_BUBBLE`=1. A flush counter decrements each cycle; the state returns to RUN when it reaches 0.
  3. `BRANCH_TAKEN`=1, or `pend_br`=1: `PC_WRITE_EN`=1, `IF_ID_FLUSH`=1, `ID_EX_BUBBLE`=1.
     - Next state is FLUSH, with the counter loaded to `FLUSH_CYCLES`-1, if `FLUSH_CYCLES`>1; otherwise RUN.
     - `FLUSH_COUNT` increments.
     - `pend_br` clears.
  4. `lu`=1: `PC_WRITE_EN`=0, `IF_ID_WRITE_EN`=0, `ID_EX_BUBBLE`=1 (single-cycle stall). The hazard is gone the next cycle because the load has moved to MEM.
  5. `IMEM_BUSYWAIT`=1: `PC_WRITE_EN`=0, `IF_ID_WRITE_EN`=0, `ID_EX_BUBBLE`=1.
  6. Otherwise: all write-enables 1, no flush, no bubble.
- MEM_WAIT handling:
  - A `BRANCH_TAKEN` that arrives while `DMEM_BUSYWAIT`=1 sets `pend_br`.
  - The branch is applied (case 3) on the first cycle after `DMEM_BUSYWAIT` falls.
  - Leaving MEM_WAIT goes to RUN, or to FLUSH via case 3.
- `IF_ID_FLUSH` and `IF_ID_WRITE_EN` are never both 0 while `ID_EX_BUBBLE`=1 in case 3; a flush always overrides `lu` and the IMEM stall.
- Counters saturate at all-ones.
  - `STALL_COUNT` increments on every rising edge where `PC_WRITE_EN`=0.
  - `FLUSH_COUNT` increments on every case-3 edge.

## Timing
- `RESET` low, asynchronously:
  - state=RUN, `pend_br`=0, flush counter=0, `STALL_COUNT`=0, `FLUSH_COUNT`=0.
  - Outputs while `RESET`=0: `PC_WRITE_EN`=0, `IF_ID_WRITE_EN`=0, `IF_ID_FLUSH`=1, `ID_EX_BUBBLE`=1.
- First rising edge after `RESET` deasserts: normal RUN behaviour. A reset in the middle of FLUSH or MEM_WAIT discards the pending branch.
- Control latency is zero cycles: a hazard input affects the outputs in the same cycle, and the state changes at the next edge.
- A load-use stall costs exactly 1 cycle. A taken branch costs `FLUSH_CYCLES` cycles of squash. A DMEM wait costs N cycles, where N is the number of busy cycles.
- `BRANCH_TAKEN` and `lu` in the same cycle: the flush wins; no stall is counted.
- `BRANCH_TAKEN` and `IMEM_BUSYWAIT` in the same cycle: `PC_WRITE_EN`=1 so the redirect target is latched. Later fetch stalls are handled by case 5.

## Structure
- Shared package `pipeline_ctrl_pkg`:
  - state enum `ctrl_state_t` {RUN, MEM_WAIT, FLUSH};
  - constant `NOP_INSTR`=32'h00000013;
  - typedef `ctrl_word_t`, a struct of the four control outputs.
- One sub-module, `sat_counter` (`CNT_W`-wide, enable, async active-low clear), instantiated twice.
- The state register and next-state/priority logic stay in this block.

## Test plan
- Reset with `RESET`=0 in the middle of FLUSH:
  - outputs show (`PC_WRITE_EN`=0, `IF_ID_WRITE_EN`=0, `IF_ID_FLUSH`=1, `ID_EX_BUBBLE`=1) immediately;
  - counters are 0;
  - after release, RUN with all enables=1.
- Load-use: `EX_MEM_READ`=1, `EX_RD`=5, `ID_RS2`=5 for one cycle:
  - `PC_WRITE_EN`=0, `IF_ID_WRITE_EN`=0, `ID_EX_BUBBLE`=1 for exactly 1 cycle;
  - `STALL_COUNT`=1.
  - With `EX_RD`=0 instead: no stall.
- Branch plus load-use in the same cycle, `FLUSH_CYCLES`=2:
  - `IF_ID_FLUSH`=1 for 2 cycles; `FLUSH_COUNT`=1; `STALL_COUNT` unchanged.
- `DMEM_BUSYWAIT` high for 4 cycles with a `BRANCH_TAKEN` pulse in cycle 2:
  - full freeze for 4 cycles;
  - cycle 5 shows `IF_ID_FLUSH`=1;
  - `STALL_COUNT`=4, `FLUSH_COUNT`=1.
- `IMEM_BUSYWAIT` high for 3 cycles: `PC_WRITE_EN`=0 and `ID_EX_BUBBLE`=1 for 3 cycles, then normal flow.
- Saturation with `CNT_W`=4: 20 stall cycles give `STALL_COUNT`=15 held.
